// File: rtl/sc_scbc_plm_pkg.sv
// Shared types and constants for the SCBC ULPI PLL lock monitor.
// Holds the FSM state encoding and the helpers used to size the counters.
package sc_scbc_pkg;

  typedef enum logic [1:0] {
    PLM_OFF    = 2'd0,
    PLM_QUIET  = 2'd1,
    PLM_LOCKED = 2'd2,
    PLM_TMO    = 2'd3
  } plm_state_t;

  localparam int PLM_MIN_SYNC = 2;

  function automatic int plm_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sc_scbc_plm_if.sv
// PHY-facing and status signals of the lock monitor, bundled for port use.
// The monitor itself takes the master view; whoever drives WAKEUP/DIR takes slave.
interface sc_scbc_plm_if;
  import sc_scbc_pkg::*;

  logic       WAKEUP;
  logic       DIR;
  logic       STAT_CLR;
  logic       ULPIRSTB;
  logic       LOCKED;
  logic       TIMEOUT;
  logic       LOCK_LOST;
  plm_state_t STATE;

  modport master (
    input  WAKEUP, DIR, STAT_CLR,
    output ULPIRSTB, LOCKED, TIMEOUT, LOCK_LOST, STATE
  );

  modport slave (
    output WAKEUP, DIR, STAT_CLR,
    input  ULPIRSTB, LOCKED, TIMEOUT, LOCK_LOST, STATE
  );

endinterface

// File: rtl/sc_scbc_sync.sv
// Single-bit multi-flop synchroniser with async active-low reset.
// RST_VAL lets the DIR path come out of reset reading "high" so lock needs real low samples.
module sc_scbc_sync
  import sc_scbc_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < PLM_MIN_SYNC) begin : g_bad_stages
    $error("sc_scbc_sync: STAGES must be >= %0d", PLM_MIN_SYNC);
  end

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/sc_scbc_plm.sv
// PLL lock monitor for the SCBC ULPI interface: waits for a run of DIR-low samples,
// releases ULPIRSTB, and watches for timeout and stuck-high DIR afterwards.
module sc_scbc_plm
  import sc_scbc_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STUCK_CYCLES   = 1024,
  parameter int AUTO_RELOCK    = 1
) (
  input  logic          ULPICLK,
  input  logic          SYSRSTB,
  sc_scbc_plm_if.master bus
);

  localparam int CNT_W = $clog2(plm_max3(TIMEOUT_CYCLES, STUCK_CYCLES, LOCK_CYCLES) + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_SAT  = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  if (SYNC_STAGES < PLM_MIN_SYNC) begin : g_bad_sync
    $error("sc_scbc_plm: SYNC_STAGES must be >= %0d", PLM_MIN_SYNC);
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("sc_scbc_plm: LOCK_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES <= LOCK_CYCLES) begin : g_bad_tmo
    $error("sc_scbc_plm: TIMEOUT_CYCLES must be > LOCK_CYCLES");
  end
  if (STUCK_CYCLES < 2) begin : g_bad_stuck
    $error("sc_scbc_plm: STUCK_CYCLES must be >= 2");
  end
  if ((AUTO_RELOCK != 0) && (AUTO_RELOCK != 1)) begin : g_bad_relock
    $error("sc_scbc_plm: AUTO_RELOCK must be 0 or 1");
  end

  logic wake_s;
  logic dir_s;

  sc_scbc_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_wake (
    .clk   (ULPICLK),
    .rst_n (SYSRSTB),
    .d     (bus.WAKEUP),
    .q     (wake_s)
  );

  sc_scbc_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_dir (
    .clk   (ULPICLK),
    .rst_n (SYSRSTB),
    .d     (bus.DIR),
    .q     (dir_s)
  );

  plm_state_t       state_reg, state_next;
  logic [CNT_W-1:0] lcnt_reg, lcnt_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic [CNT_W-1:0] scnt_reg, scnt_next;
  logic             ulpirstb_reg, ulpirstb_next;
  logic             locked_reg, locked_next;
  logic             timeout_reg, timeout_next;
  logic             lock_lost_reg, lock_lost_next;
  logic             timeout_set;
  logic             lock_lost_set;

  always_ff @(posedge ULPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state_reg     <= PLM_OFF;
      lcnt_reg      <= '0;
      tcnt_reg      <= '0;
      scnt_reg      <= '0;
      ulpirstb_reg  <= 1'b0;
      locked_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lcnt_reg      <= lcnt_next;
      tcnt_reg      <= tcnt_next;
      scnt_reg      <= scnt_next;
      ulpirstb_reg  <= ulpirstb_next;
      locked_reg    <= locked_next;
      timeout_reg   <= timeout_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lcnt_next     = lcnt_reg;
    tcnt_next     = tcnt_reg;
    scnt_next     = scnt_reg;
    timeout_set   = 1'b0;
    lock_lost_set = 1'b0;

    // Loss of wakeup overrides every other transition, including a lock on the same edge.
    if (!wake_s) begin
      state_next = PLM_OFF;
      lcnt_next  = '0;
      tcnt_next  = '0;
      scnt_next  = '0;
    end else begin
      case (state_reg)
        PLM_OFF: begin
          state_next = PLM_QUIET;
          lcnt_next  = '0;
          tcnt_next  = '0;
          scnt_next  = '0;
        end

        PLM_QUIET: begin
          tcnt_next = tcnt_reg + CNT_ONE;
          lcnt_next = dir_s ? '0 : (lcnt_reg + CNT_ONE);
          if (!dir_s && (lcnt_reg == LOCK_LAST)) begin
            state_next = PLM_LOCKED;
            scnt_next  = '0;
          end else if (tcnt_reg == TMO_LAST) begin
            state_next  = PLM_TMO;
            timeout_set = 1'b1;
          end
        end

        PLM_LOCKED: begin
          if (!dir_s) begin
            scnt_next = '0;
          end else if (scnt_reg == STUCK_LAST) begin
            lock_lost_set = 1'b1;
            if (AUTO_RELOCK != 0) begin
              state_next = PLM_QUIET;
              lcnt_next  = '0;
              tcnt_next  = '0;
              scnt_next  = '0;
            end else begin
              // Parking above the trigger value keeps a held-high DIR from re-firing.
              scnt_next = STUCK_SAT;
            end
          end else if (scnt_reg != STUCK_SAT) begin
            scnt_next = scnt_reg + CNT_ONE;
          end
        end

        PLM_TMO: begin
          state_next = PLM_TMO;
        end

        default: begin
          state_next = PLM_OFF;
        end
      endcase
    end

    locked_next    = (state_next == PLM_LOCKED);
    ulpirstb_next  = locked_next;
    timeout_next   = timeout_set | (timeout_reg & ~bus.STAT_CLR);
    lock_lost_next = lock_lost_set | (lock_lost_reg & ~bus.STAT_CLR);
  end

  assign bus.ULPIRSTB  = ulpirstb_reg;
  assign bus.LOCKED    = locked_reg;
  assign bus.TIMEOUT   = timeout_reg;
  assign bus.LOCK_LOST = lock_lost_reg;
  assign bus.STATE     = state_reg;

endmodule
